// File: rtl/issue_hazard_controller.sv
// Decode-stage issue controller: per-register pending-write scoreboard, RAW/WAW-depth
// hazard detection, branch serialisation and a fixed-length flush window after taken branches.
module issue_hazard_controller #(
  parameter int NREGS        = 16,
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 3,
  parameter int PC_REG       = 14,
  parameter int FLUSH_CYC    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      instruction,
  input  logic             wb_valid,
  input  logic [3:0]       wb_rd,
  input  logic             br_resolve,
  input  logic             br_taken,
  output logic             issue,
  output logic             stall,
  output logic             flush,
  output logic [NREGS-1:0] pending,
  output logic             err
);

  localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_BR_WAIT = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [FC_W-1:0]   r_fcnt;
  logic [FC_W-1:0]   w_fcnt_next;
  logic [CNT_W-1:0]  r_cnt [NREGS];
  logic [CNT_W-1:0]  w_cnt_next [NREGS];
  logic              r_err;

  logic [1:0]        w_ft;
  logic [1:0]        w_fc;
  logic [3:0]        w_rd;
  logic [3:0]        w_rs;
  logic [3:0]        w_rx;
  logic              w_selimm;
  logic              w_is_alu;
  logic              w_dst_we;
  logic [3:0]        w_src_a;
  logic              w_src_a_used;
  logic              w_src_b_used;
  logic              w_hazard;
  logic              w_run;
  logic              w_wb_underflow;
  logic [NREGS-1:0]  w_inc;
  logic [NREGS-1:0]  w_dec;
  logic              w_unused;

  assign w_ft     = instruction[31:30];
  assign w_fc     = instruction[29:28];
  assign w_rd     = instruction[27:24];
  assign w_rs     = instruction[23:20];
  assign w_rx     = instruction[19:16];
  assign w_selimm = instruction[0];
  assign w_unused = &{1'b0, instruction[15:1]};

  assign w_is_alu = (w_ft == 2'b00) && (w_fc != 2'b11);
  assign w_dst_we = (w_is_alu || ((w_ft == 2'b01) && (w_fc == 2'b00)) ||
                     ((w_ft == 2'b11) && !w_fc[0])) && (w_rd != 4'(PC_REG));

  // Compare-type ALU ops and non-ALU ops read their first operand from the rd field.
  assign w_src_a      = w_is_alu ? w_rs : w_rd;
  assign w_src_a_used = !(((w_ft == 2'b00) && (w_fc == 2'b10)) || (w_ft == 2'b11)) &&
                        (w_src_a != 4'(PC_REG));
  assign w_src_b_used = !w_selimm && (w_rx != 4'(PC_REG));

  assign w_hazard = (w_src_a_used && (r_cnt[w_src_a] != '0)) ||
                    (w_src_b_used && (r_cnt[w_rx] != '0)) ||
                    (w_dst_we && (r_cnt[w_rd] == CNT_W'(MAX_INFLIGHT)));

  assign w_run = (r_state == S_RUN);
  assign issue = if_valid && w_run && !w_hazard;
  assign stall = if_valid && !issue;
  assign flush = (r_state == S_FLUSH);
  assign err   = r_err;

  assign w_wb_underflow = wb_valid && (wb_rd != 4'(PC_REG)) && (r_cnt[wb_rd] == '0);

  // PC alias never increments (dst_we gated) and never decrements (counter stays zero).
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    assign w_inc[gi]   = issue && w_dst_we && (w_rd == 4'(gi));
    assign w_dec[gi]   = wb_valid && (wb_rd == 4'(gi)) && (r_cnt[gi] != '0);
    assign pending[gi] = (r_cnt[gi] != '0);
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (w_inc[i] && !w_dec[i]) begin
        w_cnt_next[i] = r_cnt[i] + 1'b1;
      end else if (w_dec[i] && !w_inc[i]) begin
        w_cnt_next[i] = r_cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_fcnt_next  = r_fcnt;
    case (r_state)
      S_RUN: begin
        if (issue && (w_ft == 2'b10)) w_state_next = S_BR_WAIT;
      end
      S_BR_WAIT: begin
        if (br_resolve) begin
          if (br_taken) begin
            w_state_next = S_FLUSH;
            w_fcnt_next  = FC_W'(FLUSH_CYC - 1);
          end else begin
            w_state_next = S_RUN;
          end
        end
      end
      S_FLUSH: begin
        if (r_fcnt == '0) w_state_next = S_RUN;
        else              w_fcnt_next  = r_fcnt - FC_W'(1);
      end
      default: w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_fcnt  <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_state_next;
      r_fcnt  <= w_fcnt_next;
      r_err   <= r_err | w_wb_underflow;
      for (int i = 0; i < NREGS; i++) r_cnt[i] <= w_cnt_next[i];
    end
  end

endmodule

// File: tb/tb_issue_hazard_controller.sv
// Bench for issue_hazard_controller: directed scenarios then random traffic, every cycle
// compared against a behavioural scoreboard model.
module tb_issue_hazard_controller;

  localparam int PC     = 14;
  localparam int MAXF   = 3;
  localparam int NFLUSH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] instruction;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic        br_resolve;
  logic        br_taken;
  logic        issue;
  logic        stall;
  logic        flush;
  logic [15:0] pending;
  logic        err;

  always #5 clk = ~clk;

  issue_hazard_controller dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .instruction (instruction),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .br_resolve  (br_resolve),
    .br_taken    (br_taken),
    .issue       (issue),
    .stall       (stall),
    .flush       (flush),
    .pending     (pending),
    .err         (err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: outstanding writes per register, sticky error, mode 0=run 1=branch wait 2=flush.
  int m_cnt [16];
  bit m_err;
  int m_mode;
  int m_fleft;

  localparam logic [31:0] ADD  = 32'h01230000;
  localparam logic [31:0] RDR1 = 32'h04150000;
  localparam logic [31:0] CMP  = 32'h32300000;
  localparam logic [31:0] BR   = 32'h80000040;
  localparam logic [31:0] W5   = 32'h05000001;

  function automatic int fld(logic [31:0] ins, int lsb, int w);
    return int'(ins >> lsb) & ((1 << w) - 1);
  endfunction

  function automatic bit m_writes(logic [31:0] ins);
    int ft = fld(ins, 30, 2);
    int fc = fld(ins, 28, 2);
    bit w;
    case (ft)
      0:       w = (fc != 3);
      1:       w = (fc == 0);
      3:       w = ((fc % 2) == 0);
      default: w = 1'b0;
    endcase
    return w && (fld(ins, 24, 4) != PC);
  endfunction

  function automatic bit m_blocked(logic [31:0] ins);
    int ft = fld(ins, 30, 2);
    int fc = fld(ins, 28, 2);
    int rd = fld(ins, 24, 4);
    int srcs[$];
    if (!(ft == 0 && fc == 2) && ft != 3) srcs.push_back((ft == 0 && fc != 3) ? fld(ins, 20, 4) : rd);
    if (fld(ins, 0, 1) == 0) srcs.push_back(fld(ins, 16, 4));
    foreach (srcs[k]) if (srcs[k] != PC && m_cnt[srcs[k]] > 0) return 1'b1;
    if (m_writes(ins) && m_cnt[rd] >= MAXF) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    foreach (m_cnt[k]) m_cnt[k] = 0;
    m_err   = 1'b0;
    m_mode  = 0;
    m_fleft = 0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(bit r, bit iv, logic [31:0] ins, bit wv, logic [3:0] wr,
                      bit bres, bit btk, int exp_iss = -1);
    bit          e_issue;
    logic [15:0] e_pend;
    rst = r; if_valid = iv; instruction = ins; wb_valid = wv; wb_rd = wr;
    br_resolve = bres; br_taken = btk;
    @(negedge clk);
    e_issue = iv && (m_mode == 0) && !m_blocked(ins);
    for (int k = 0; k < 16; k++) e_pend[k] = (m_cnt[k] > 0);
    chk("issue",   32'(issue),   32'(e_issue));
    chk("stall",   32'(stall),   32'(iv && !e_issue));
    chk("flush",   32'(flush),   32'(m_mode == 2));
    chk("pending", 32'(pending), 32'(e_pend));
    chk("err",     32'(err),     32'(m_err));
    if (exp_iss >= 0) chk("plan_issue", 32'(issue), 32'(exp_iss != 0));
    $display("cyc %0d rst=%0b iv=%0b ins=%08h wb=%0b/%0d br=%0b/%0b -> issue=%0b stall=%0b flush=%0b pend=%04h err=%0b",
             cyc, r, iv, ins, wv, wr, bres, btk, issue, stall, flush, pending, err);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (wv && wr != PC) begin
        if (m_cnt[wr] == 0) m_err = 1'b1;
        else                m_cnt[wr]--;
      end
      if (e_issue && m_writes(ins)) m_cnt[fld(ins, 24, 4)]++;
      case (m_mode)
        0: if (e_issue && fld(ins, 30, 2) == 2) m_mode = 1;
        1: if (bres) begin
             if (btk) begin m_mode = 2; m_fleft = NFLUSH; end
             else m_mode = 0;
           end
        default: begin
          m_fleft--;
          if (m_fleft == 0) m_mode = 0;
        end
      endcase
    end
    #1;
    cyc++;
  endtask

  function automatic logic [3:0] rand_reg();
    int p = $urandom_range(0, 99);
    if (p < 70) return 4'($urandom_range(0, 5));
    if (p < 80) return 4'(PC);
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    logic [31:0] ins;
    logic [3:0]  wr;
    int          busy[$];

    rst = 1'b1; if_valid = 1'b0; instruction = '0; wb_valid = 1'b0; wb_rd = '0;
    br_resolve = 1'b0; br_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_err",     32'(err),     32'h0);
    chk("rst_flush",   32'(flush),   32'h0);

    // RAW on R1, no bypass from writeback
    step(0, 1, ADD,  0, 0, 0, 0, 1);
    chk("plan_pend_r1", 32'(pending), 32'h0002);
    step(0, 1, RDR1, 0, 0, 0, 0, 0);
    step(0, 1, RDR1, 1, 1, 0, 0, 0);
    chk("plan_pend_clear", 32'(pending), 32'h0000);
    step(0, 1, RDR1, 0, 0, 0, 0, 1);
    step(0, 0, '0,   1, 4, 0, 0);

    // immediate operand masks source B
    step(0, 1, 32'h07000001, 0, 0, 0, 0, 1);
    step(0, 1, 32'h04170001, 0, 0, 0, 0, 1);
    step(0, 1, 32'h04170000, 0, 0, 0, 0, 0);
    step(0, 1, 32'h04170000, 1, 7, 0, 0, 0);
    step(0, 1, 32'h04170000, 0, 0, 0, 0, 1);
    step(0, 0, '0, 1, 4, 0, 0);
    step(0, 0, '0, 1, 4, 0, 0);
    chk("plan_pend_r7r4", 32'(pending), 32'h0000);

    // in-flight limit on R5
    repeat (3) step(0, 1, W5, 0, 0, 0, 0, 1);
    chk("plan_pend_r5", 32'(pending), 32'h0020);
    step(0, 1, W5, 1, 5, 0, 0, 0);
    step(0, 1, W5, 0, 0, 0, 0, 1);
    step(0, 0, '0, 1, 5, 0, 0);
    step(0, 0, '0, 1, 5, 0, 0);
    chk("plan_r5_cnt3", 32'(pending), 32'h0020);
    step(0, 0, '0, 1, 5, 0, 0);
    chk("plan_r5_empty", 32'(pending), 32'h0000);

    // compare reads rd, writes nothing
    step(0, 1, 32'h02000001, 0, 0, 0, 0, 1);
    step(0, 1, CMP, 0, 0, 0, 0, 0);
    step(0, 1, CMP, 1, 2, 0, 0, 0);
    step(0, 1, CMP, 0, 0, 0, 0, 1);
    chk("plan_cmp_nodst", 32'(pending), 32'h0000);

    // taken branch: two flush cycles
    step(0, 1, BR,  0, 0, 0, 0, 1);
    step(0, 1, ADD, 0, 0, 0, 0, 0);
    step(0, 1, ADD, 0, 0, 1, 1, 0);
    chk("plan_flush1", 32'(flush), 32'h1);
    step(0, 1, ADD, 0, 0, 0, 0, 0);
    chk("plan_flush2", 32'(flush), 32'h1);
    step(0, 1, ADD, 0, 0, 0, 0, 0);
    chk("plan_flush_end", 32'(flush), 32'h0);
    step(0, 1, ADD, 0, 0, 0, 0, 1);
    step(0, 0, '0,  1, 1, 0, 0);

    // not-taken branch: no flush
    step(0, 1, BR,  0, 0, 0, 0, 1);
    step(0, 1, ADD, 0, 0, 1, 0, 0);
    chk("plan_nt_noflush", 32'(flush), 32'h0);
    step(0, 1, ADD, 0, 0, 0, 0, 1);
    step(0, 0, '0,  1, 1, 0, 0);

    // sticky error, PC writeback ignored, reset inside branch wait
    chk("plan_err_before", 32'(err), 32'h0);
    step(0, 0, '0, 1, 9, 0, 0);
    chk("plan_err_set", 32'(err), 32'h1);
    step(0, 0, '0, 1, 14, 0, 0);
    chk("plan_err_pc", 32'(err), 32'h1);
    step(0, 1, ADD, 0, 0, 0, 0, 1);
    step(0, 1, BR,  0, 0, 0, 0, 1);
    step(1, 1, ADD, 0, 0, 0, 0, 0);
    chk("plan_rst_pend", 32'(pending), 32'h0);
    chk("plan_rst_err",  32'(err),     32'h0);
    step(0, 1, ADD, 0, 0, 0, 0, 1);
    chk("plan_rst_run", 32'(pending), 32'h0002);

    // random traffic against the model
    for (int t = 0; t < 1500; t++) begin
      ins = $urandom;
      ins[27:24] = rand_reg();
      ins[23:20] = rand_reg();
      ins[19:16] = rand_reg();
      busy.delete();
      for (int k = 0; k < 16; k++) if (m_cnt[k] > 0) busy.push_back(k);
      if (busy.size() > 0 && $urandom_range(0, 99) < 80)
        wr = 4'(busy[$urandom_range(0, busy.size() - 1)]);
      else
        wr = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 8), ins,
           ($urandom_range(0, 99) < 45), wr,
           (m_mode == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
